// File: rtl/stream_pkg.sv
// Shared types and helpers for the valid/stall streaming fabric.
package stream_pkg;

    localparam int unsigned STREAM_WIDTH = 32;

    // Transfer kind seen by a buffer in one cycle, encoded as {pop, push}.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        PUSH = 2'b01,
        POP  = 2'b10,
        BOTH = 2'b11
    } stream_xfer_e;

    // Advance a ring pointer, wrapping from depth-1 back to 0 for any depth.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = 2
) (
    input  logic             clock,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Elastic buffer for the valid/stall fabric with occupancy, almost-full and flush.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int unsigned  WIDTH     = STREAM_WIDTH,
    parameter int unsigned  DEPTH     = 4,
    parameter int unsigned  AF_THRESH = DEPTH - 1,
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             upstream_stall,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             downstream_stall,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, valid_q, af_q;
    logic             push_c, pop_c;
    stream_xfer_e     xfer_c;
    logic [WIDTH-1:0] rd_data_c;

    // Handshake decode and next pointer/count; flush wins over any transfer.
    always_comb begin
        push_c   = in_valid && !full_q;
        pop_c    = valid_q && !downstream_stall;
        xfer_c   = stream_xfer_e'({pop_c, push_c});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (xfer_c)
                PUSH: begin
                    wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
                    count_d  = count_q + CW'(1);
                end
                POP: begin
                    rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
                    count_d  = count_q - CW'(1);
                end
                BOTH: begin
                    wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
                    rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
                end
                default: begin
                end
            endcase
        end
    end

    // State and flag registers; flags are precomputed from the next count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            valid_q  <= (count_d != '0);
            af_q     <= (count_d >= CW'(AF_THRESH));
        end
    end

    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clock (clock),
        .we    (push_c && !flush && !reset),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data_c)
    );

    assign upstream_stall = full_q;
    assign out_valid      = valid_q;
    assign out_data       = valid_q ? rd_data_c : '0;
    assign count          = count_q;
    assign almost_full    = af_q;

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;
    import stream_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DEPTH=4, AF_THRESH=3 instance
    logic        r4 = 1'b1, f4 = 1'b0, iv4 = 1'b0, ds4 = 1'b1;
    logic [31:0] d4 = '0;
    logic        us4, ov4, af4;
    logic [31:0] od4;
    logic [2:0]  c4;

    // DEPTH=3, AF_THRESH=2 instance
    logic        r3 = 1'b1, f3 = 1'b0, iv3 = 1'b0, ds3 = 1'b1;
    logic [31:0] d3 = '0;
    logic        us3, ov3, af3;
    logic [31:0] od3;
    logic [1:0]  c3;

    stream_fifo #(.WIDTH(32), .DEPTH(4)) dut4 (
        .clock(clock), .reset(r4), .flush(f4), .in_data(d4), .in_valid(iv4),
        .upstream_stall(us4), .out_data(od4), .out_valid(ov4),
        .downstream_stall(ds4), .count(c4), .almost_full(af4)
    );

    stream_fifo #(.WIDTH(32), .DEPTH(3), .AF_THRESH(2)) dut3 (
        .clock(clock), .reset(r3), .flush(f3), .in_data(d3), .in_valid(iv3),
        .upstream_stall(us3), .out_data(od3), .out_valid(ov3),
        .downstream_stall(ds3), .count(c3), .almost_full(af3)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ds;
        logic [2:0]  cnt;
        logic        vld;
        logic [31:0] od;
        logic        stl;
        logic        af;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv, input logic [31:0] d,
                                input logic ds, input logic [2:0] cnt, input logic [31:0] od, input logic stl);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ds = ds;
        v.cnt = cnt; v.vld = (cnt != 0); v.od = od; v.stl = stl; v.af = (cnt >= 3);
        return v;
    endfunction

    initial begin
        logic [31:0] q[$];
        logic        acc, pop, full;
        int          s;

        // reset both instances
        tick(); tick();
        r4 = 1'b0; r3 = 1'b0;
        iv4 = 1'b0; ds4 = 1'b0;

        // reset then idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(ov4), 32'd0);
            chk("idle_data", od4, 32'd0);
            chk("idle_count", 32'(c4), 32'd0);
            chk("idle_stall", 32'(us4), 32'd0);
        end

        // fill/drain, full-with-pop, flush and reset-over-flush vectors
        tv.push_back(mk(0,0,1,32'hA0,1, 1,32'hA0,0));
        tv.push_back(mk(0,0,1,32'hA1,1, 2,32'hA0,0));
        tv.push_back(mk(0,0,1,32'hA2,1, 3,32'hA0,0));
        tv.push_back(mk(0,0,1,32'hA3,1, 4,32'hA0,1));
        tv.push_back(mk(0,0,1,32'hA4,1, 4,32'hA0,1));
        tv.push_back(mk(0,0,1,32'hA5,1, 4,32'hA0,1));
        tv.push_back(mk(0,0,0,32'h0, 0, 3,32'hA1,0));
        tv.push_back(mk(0,0,0,32'h0, 0, 2,32'hA2,0));
        tv.push_back(mk(0,0,0,32'h0, 0, 1,32'hA3,0));
        tv.push_back(mk(0,0,0,32'h0, 0, 0,32'h0, 0));
        tv.push_back(mk(0,0,1,32'hB0,1, 1,32'hB0,0));
        tv.push_back(mk(0,0,1,32'hB1,1, 2,32'hB0,0));
        tv.push_back(mk(0,0,1,32'hB2,1, 3,32'hB0,0));
        tv.push_back(mk(0,0,1,32'hB3,1, 4,32'hB0,1));
        tv.push_back(mk(0,0,1,32'hC0,0, 3,32'hB1,0));
        tv.push_back(mk(0,0,1,32'hC1,0, 3,32'hB2,0));
        tv.push_back(mk(0,0,0,32'h0, 0, 2,32'hB3,0));
        tv.push_back(mk(0,0,0,32'h0, 0, 1,32'hC1,0));
        tv.push_back(mk(0,0,0,32'h0, 0, 0,32'h0, 0));
        tv.push_back(mk(0,0,1,32'hD0,1, 1,32'hD0,0));
        tv.push_back(mk(0,0,1,32'hD1,1, 2,32'hD0,0));
        tv.push_back(mk(0,0,1,32'hD2,1, 3,32'hD0,0));
        tv.push_back(mk(0,0,1,32'hD3,1, 4,32'hD0,1));
        tv.push_back(mk(0,1,1,32'hEE,0, 0,32'h0, 0));
        tv.push_back(mk(0,0,1,32'h77,1, 1,32'h77,0));
        tv.push_back(mk(1,1,1,32'h55,1, 0,32'h0, 0));
        tv.push_back(mk(0,0,1,32'h66,1, 1,32'h66,0));
        tv.push_back(mk(0,0,0,32'h0, 0, 0,32'h0, 0));

        foreach (tv[i]) begin
            r4 = tv[i].rst; f4 = tv[i].fl; iv4 = tv[i].iv; d4 = tv[i].d; ds4 = tv[i].ds;
            tick();
            chk($sformatf("vec%0d_count", i), 32'(c4), 32'(tv[i].cnt));
            chk($sformatf("vec%0d_valid", i), 32'(ov4), 32'(tv[i].vld));
            chk($sformatf("vec%0d_data", i), od4, tv[i].od);
            chk($sformatf("vec%0d_stall", i), 32'(us4), 32'(tv[i].stl));
            chk($sformatf("vec%0d_af", i), 32'(af4), 32'(tv[i].af));
        end
        r4 = 1'b0; f4 = 1'b0;

        // streaming with no downstream stall: 1-cycle latency, count stays at 1
        for (int i = 0; i < 100; i++) begin
            iv4 = 1'b1; d4 = 32'h1000 + 32'(i); ds4 = 1'b0;
            tick();
            chk("stream_data", od4, 32'h1000 + 32'(i));
            chk("stream_valid", 32'(ov4), 32'd1);
            chk("stream_count", 32'(c4), 32'd1);
        end
        iv4 = 1'b0;
        tick();
        chk("stream_drain_valid", 32'(ov4), 32'd0);
        chk("stream_drain_count", 32'(c4), 32'd0);

        // randomized DEPTH=3 run against a queue model
        for (int cyc = 0; cyc < 10000; cyc++) begin
            iv3 = 1'($urandom_range(0, 1));
            d3  = $urandom;
            ds3 = ($urandom_range(0, 2) == 0);
            f3  = ($urandom_range(0, 299) == 0);
            full = (q.size() == 3);
            acc  = iv3 && !full;
            pop  = (q.size() > 0) && !ds3;
            tick();
            if (f3) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(d3);
            end
            s = q.size();
            chk("rnd_count", 32'(c3), 32'(s));
            chk("rnd_valid", 32'(ov3), 32'(s != 0));
            chk("rnd_data", od3, (s != 0) ? q[0] : 32'd0);
            chk("rnd_stall", 32'(us3), 32'(s == 3));
            chk("rnd_af", 32'(af3), 32'(s >= 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
